edca_backoff_counter: RTL and testbench

EDCA_BACKOFF_COUNTER -- requirements
Module: edca_backoff_counter

---
 rtl/edca_backoff_counter_if.sv | 25 ++
 rtl/edca_backoff_counter.sv | 137 +++++++++++++
 tb/tb_edca_backoff_counter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edca_backoff_counter_if.sv
// Signal bundle between the EDCA backoff counter and its MAC-side controller.
// The 17x17 backoff multiplier sits on the controller side of this bundle.
interface edca_backoff_counter_if;
    logic        start;
    logic        abort;
    logic [15:0] cw;
    logic        slot_tick;
    logic        medium_busy;
    logic [16:0] mul_a;
    logic [16:0] mul_b;
    logic [31:0] mul_p;
    logic        active;
    logic [15:0] slots_left;
    logic        backoff_done;

    modport master (
        output start, abort, cw, slot_tick, medium_busy, mul_p,
        input  mul_a, mul_b, active, slots_left, backoff_done
    );

    modport slave (
        input  start, abort, cw, slot_tick, medium_busy, mul_p,
        output mul_a, mul_b, active, slots_left, backoff_done
    );
endinterface

// File: rtl/edca_backoff_counter.sv
// EDCA random backoff counter: draws slots_left = floor(rand * (cw+1) / 2^16),
// waits AIFSN idle slots, then counts idle slots down, re-arming AIFS on busy.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; LFSR free-running
// S_CALC  | one cycle: capture scaled backoff from the external multiplier
// S_AIFS  | counting consecutive idle slot ticks up to AIFSN
// S_COUNT | decrementing slots_left on each idle slot tick
// S_DONE  | one-cycle backoff_done pulse
module edca_backoff_counter #(
    parameter int unsigned AIFSN     = 2,       // must be >= 1
    parameter logic [15:0] LFSR_SEED = 16'hACE1 // must be nonzero
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    edca_backoff_counter_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_AIFS,
        S_COUNT,
        S_DONE
    } state_t;

    localparam int unsigned         AIFS_W    = (AIFSN < 1) ? 1 : $clog2(AIFSN + 1);
    localparam logic [AIFS_W-1:0]   AIFS_LAST = AIFS_W'(AIFSN);
    localparam logic [15:0]         LFSR_TAPS = 16'hB400;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_lfsr;
    logic [15:0]         w_lfsr_nxt;
    logic [15:0]         r_rand;
    logic [15:0]         w_rand_nxt;
    logic [15:0]         r_cw;
    logic [15:0]         w_cw_nxt;
    logic [AIFS_W-1:0]   r_aifs_cnt;
    logic [AIFS_W-1:0]   w_aifs_nxt;
    logic [AIFS_W-1:0]   w_aifs_inc;
    logic [15:0]         r_slots;
    logic [15:0]         w_slots_nxt;
    logic                w_idle_tick;
    logic                w_unused_mul_lo;

    // Galois form, shifting right; taps for x^16+x^14+x^13+x^11+1
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);

    // Busy wins over a coincident tick in both waiting phases
    assign w_idle_tick = bus.slot_tick & ~bus.medium_busy;
    assign w_aifs_inc  = r_aifs_cnt + AIFS_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_rand_nxt  = r_rand;
        w_cw_nxt    = r_cw;
        w_aifs_nxt  = r_aifs_cnt;
        w_slots_nxt = r_slots;

        if ((r_state != S_IDLE) && bus.abort) begin
            w_state_nxt = S_IDLE;
            w_aifs_nxt  = '0;
            w_slots_nxt = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        w_rand_nxt  = r_lfsr;
                        w_cw_nxt    = bus.cw;
                        w_state_nxt = S_CALC;
                    end
                end
                S_CALC: begin
                    w_slots_nxt = bus.mul_p[31:16];
                    w_aifs_nxt  = '0;
                    w_state_nxt = S_AIFS;
                end
                S_AIFS: begin
                    if (bus.medium_busy) begin
                        w_aifs_nxt = '0;
                    end else if (w_idle_tick) begin
                        w_aifs_nxt = w_aifs_inc;
                        if (w_aifs_inc == AIFS_LAST) begin
                            w_state_nxt = (r_slots == 16'd0) ? S_DONE : S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    if (bus.medium_busy) begin
                        w_aifs_nxt  = '0;
                        w_state_nxt = S_AIFS;
                    end else if (w_idle_tick) begin
                        w_slots_nxt = r_slots - 16'd1;
                        if (r_slots == 16'd1) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state    <= S_IDLE;
            r_lfsr     <= LFSR_SEED;
            r_rand     <= '0;
            r_cw       <= '0;
            r_aifs_cnt <= '0;
            r_slots    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_rand     <= w_rand_nxt;
            r_cw       <= w_cw_nxt;
            r_aifs_cnt <= w_aifs_nxt;
            r_slots    <= w_slots_nxt;
        end
    end

    // 17-bit operand B so cw = 16'hFFFF yields 17'h10000 rather than wrapping
    assign bus.mul_a        = {1'b0, r_rand};
    assign bus.mul_b        = {1'b0, r_cw} + 17'd1;
    assign bus.active       = (r_state != S_IDLE);
    assign bus.slots_left   = r_slots;
    assign bus.backoff_done = (r_state == S_DONE) && !bus.abort;

    // Only the integer part of the scaled product is used
    assign w_unused_mul_lo = ^bus.mul_p[15:0];
endmodule

// File: tb/tb_edca_backoff_counter.sv
// Randomised + directed bench for edca_backoff_counter with a timed-expectation
// scoreboard fed by a slot-level reference model.
module tb_edca_backoff_counter;
    localparam int AIFSN = 2;

    localparam int K_DONE   = 0;
    localparam int K_ACTIVE = 1;
    localparam int K_SLOTS  = 2;
    localparam int K_MULA   = 3;
    localparam int K_MULB   = 4;
    localparam int K_NDONE  = 5;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic ap_clk;
    logic ap_rst_n;
    edca_backoff_counter_if bif ();

    edca_backoff_counter #(.AIFSN(AIFSN), .LFSR_SEED(16'hACE1)) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (bif.slave)
    );

    // External combinational backoff multiplier
    assign bif.mul_p = {15'b0, bif.mul_a} * {15'b0, bif.mul_b};

    exp_t        sb[$];
    int          n_err = 0;
    int          n_chk = 0;
    int          cyc   = 0;
    bit          fin = 0;
    bit          fin_done = 0;
    bit          hold_rst = 1;
    logic [15:0] m_lfsr;

    // Reference model of the backoff procedure in slot terms
    bit          m_act, m_calc, m_cnt, m_done;
    int          m_aifs, m_slots;
    logic [15:0] m_rand, m_cw;

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    always @(posedge ap_clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_next(logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) m_lfsr <= 16'hACE1;
        else           m_lfsr <= lfsr_next(m_lfsr);
    end

    function automatic string kname(int k);
        case (k)
            K_DONE:   return "backoff_done";
            K_ACTIVE: return "active";
            K_SLOTS:  return "slots_left";
            K_MULA:   return "mul_a";
            K_MULB:   return "mul_b";
            default:  return "no_done";
        endcase
    endfunction

    function automatic logic [31:0] sample(int k);
        case (k)
            K_DONE, K_NDONE: return {31'b0, bif.backoff_done};
            K_ACTIVE:        return {31'b0, bif.active};
            K_SLOTS:         return {16'b0, bif.slots_left};
            K_MULA:          return {15'b0, bif.mul_a};
            default:         return {15'b0, bif.mul_b};
        endcase
    endfunction

    task automatic push(int c, int k, logic [31:0] v);
        exp_t e;
        int   i;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > c) i--;
        sb.insert(i, e);
    endtask

    task automatic model_reset();
        m_act = 0; m_calc = 0; m_cnt = 0; m_done = 0;
        m_aifs = 0; m_slots = 0; m_rand = '0; m_cw = '0;
    endtask

    // One clock cycle of stimulus; expectations for this cycle come from the
    // model state before it absorbs this cycle's inputs.
    task automatic drive(input bit st, input bit ab, input bit tk, input bit bz,
                         input logic [15:0] cwv);
        int c;
        @(posedge ap_clk);
        #1;
        c = cyc;
        ap_rst_n        = !hold_rst;
        bif.start       = st;
        bif.abort       = ab;
        bif.slot_tick   = tk;
        bif.medium_busy = bz;
        bif.cw          = cwv;
        push(c, K_ACTIVE, 32'(m_act));
        push(c, K_SLOTS,  m_calc ? 32'd0 : 32'(m_slots));
        push(c, K_MULA,   32'(m_rand));
        push(c, K_MULB,   32'({1'b0, m_cw}) + 32'd1);
        if (hold_rst) begin
            // held in reset: inputs have no effect
        end else if (m_done) begin
            if (!ab) push(c, K_DONE, 32'd1);
            m_done = 0; m_act = 0; m_cnt = 0;
        end else if (!m_act) begin
            if (st && !ab) begin
                m_rand  = m_lfsr;
                m_cw    = cwv;
                m_slots = int'((longint'(m_lfsr) * (longint'(cwv) + 64'd1)) >> 16);
                m_act   = 1;
                m_calc  = 1;
            end
        end else if (ab) begin
            m_act = 0; m_calc = 0; m_cnt = 0; m_slots = 0;
        end else if (m_calc) begin
            m_calc = 0; m_aifs = 0; m_cnt = 0;
        end else if (!m_cnt) begin
            if (bz) m_aifs = 0;
            else if (tk) begin
                m_aifs++;
                if (m_aifs == AIFSN) begin
                    if (m_slots == 0) m_done = 1;
                    else              m_cnt  = 1;
                end
            end
        end else begin
            if (bz) begin
                m_cnt = 0; m_aifs = 0;
            end else if (tk) begin
                m_slots--;
                if (m_slots == 0) m_done = 1;
            end
        end
    endtask

    // Asynchronous reset in the middle of a cycle; release happens in the
    // next drive() call, at the start of that cycle.
    task automatic reset_pulse(int n);
        @(posedge ap_clk);
        #3;
        ap_rst_n        = 1'b0;
        hold_rst        = 1;
        bif.start       = 0;
        bif.abort       = 0;
        bif.slot_tick   = 0;
        bif.medium_busy = 0;
        while (sb.size() != 0 && sb[$].cyc >= cyc) void'(sb.pop_back());
        model_reset();
        push(cyc, K_NDONE,  32'd0);
        push(cyc, K_ACTIVE, 32'd0);
        push(cyc, K_SLOTS,  32'd0);
        push(cyc, K_MULA,   32'd0);
        push(cyc, K_MULB,   32'd1);
        repeat (n) drive(0, 0, 0, 0, 16'd0);
        hold_rst = 0;
    endtask

    // Idle until the LFSR value captured by a start next cycle meets a bound
    task automatic wait_lfsr(input bit want_small);
        logic [15:0] nx;
        for (int i = 0; i < 5000; i++) begin
            nx = lfsr_next(m_lfsr);
            if (want_small ? (nx < 16'd1024) : (nx >= 16'h4000)) break;
            drive(0, 0, 0, 0, 16'd0);
        end
    endtask

    // Scoreboard monitor
    always @(negedge ap_clk) begin
        exp_t        e;
        logic [31:0] act;
        bit          saw_done;
        saw_done = 0;
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (e.cyc != cyc) begin
                n_err++;
                $display("FAIL stale_%s cyc=%0d expected at cyc=%0d", kname(e.kind), cyc, e.cyc);
            end else begin
                act = sample(e.kind);
                if (e.kind == K_DONE) saw_done = 1;
                if (act !== e.val) begin
                    n_err++;
                    $display("FAIL %s cyc=%0d got=%0h exp=%0h", kname(e.kind), cyc, act, e.val);
                end
            end
        end
        if (bif.backoff_done !== 1'b0 && !saw_done) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_done cyc=%0d got=%b exp=0", cyc, bif.backoff_done);
        end
        if (fin && !fin_done) begin
            n_chk++;
            if (sb.size() != 0) begin
                n_err++;
                $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
            end
            fin_done = 1;
        end
    end

    initial begin
        int n;
        ap_rst_n        = 1'b0;
        bif.start       = 0;
        bif.abort       = 0;
        bif.cw          = '0;
        bif.slot_tick   = 0;
        bif.medium_busy = 0;
        model_reset();

        reset_pulse(2);

        // cw = 0: zero slots, done one cycle after the 2nd AIFS tick
        drive(1, 0, 0, 0, 16'd0);
        drive(0, 0, 0, 0, 16'd0);
        drive(0, 0, 1, 0, 16'd0);
        drive(0, 0, 1, 0, 16'd0);
        repeat (3) drive(0, 0, 0, 0, 16'd0);

        // start together with abort in IDLE is ignored
        drive(1, 1, 0, 0, 16'd5);
        repeat (2) drive(0, 0, 0, 0, 16'd0);

        // cw = FFFF: slots_left equals the captured LFSR value
        wait_lfsr(1);
        drive(1, 0, 0, 0, 16'hFFFF);
        n = m_slots;
        drive(0, 0, 0, 0, 16'hFFFF);
        repeat (2 + n) drive(0, 0, 1, 0, 16'hFFFF);
        repeat (2) drive(0, 0, 0, 0, 16'd0);

        // cw = 15: countdown frozen by busy, AIFS re-armed, then completes
        wait_lfsr(0);
        drive(1, 0, 0, 0, 16'd15);
        n = m_slots;
        drive(0, 0, 0, 0, 16'd15);
        repeat (4) drive(0, 0, 1, 0, 16'd15);
        repeat (5) drive(0, 0, 1, 1, 16'd15);
        push(cyc, K_SLOTS, 32'(n - 2));
        drive(0, 0, 1, 0, 16'd15);
        drive(0, 0, 1, 1, 16'd15);
        repeat (2) drive(0, 0, 1, 0, 16'd15);
        repeat (n - 2) drive(0, 0, 1, 0, 16'd15);
        repeat (2) drive(0, 0, 0, 0, 16'd0);

        // stray start while active, then abort in COUNT
        wait_lfsr(0);
        drive(1, 0, 0, 0, 16'd15);
        n = m_slots;
        drive(0, 0, 0, 0, 16'd15);
        repeat (3) drive(0, 0, 1, 0, 16'd15);
        drive(1, 0, 0, 0, 16'd3);
        drive(0, 0, 0, 0, 16'd3);
        push(cyc, K_SLOTS, 32'(n - 1));
        push(cyc, K_MULB, 32'd16);
        drive(0, 1, 0, 0, 16'd3);
        repeat (3) drive(0, 0, 1, 0, 16'd3);

        // async reset in COUNT; LFSR restarts from its seed
        wait_lfsr(0);
        drive(1, 0, 0, 0, 16'd15);
        drive(0, 0, 0, 0, 16'd15);
        repeat (3) drive(0, 0, 1, 0, 16'd15);
        reset_pulse(2);
        drive(1, 0, 0, 0, 16'hFFFF);
        drive(0, 0, 0, 0, 16'hFFFF);
        push(cyc, K_MULA, 32'hACE1);
        drive(0, 0, 0, 0, 16'hFFFF);
        push(cyc, K_SLOTS, 32'hACE1);
        drive(0, 1, 0, 0, 16'hFFFF);
        repeat (3) drive(0, 0, 1, 0, 16'd0);

        // randomized backoffs with busy, coincident ticks, stray starts, aborts
        for (int r = 0; r < 30; r++) begin
            logic [15:0] cwr;
            cwr = 16'($urandom_range(0, 30));
            drive(1, ($urandom_range(0, 9) == 0), 0, 0, cwr);
            for (int k = 0; k < 600 && m_act; k++) begin
                drive(($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 69) == 0) || (k == 599),
                      ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 4) == 0),
                      16'($urandom_range(0, 30)));
            end
            repeat ($urandom_range(1, 3)) drive(0, 0, $urandom_range(0, 1) == 1, 0, 16'd0);
        end

        repeat (3) drive(0, 0, 0, 0, 16'd0);
        fin = 1;
        repeat (3) @(posedge ap_clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
